// File: rtl/link_fifo.sv
// Elastic flit buffer for one switch port: first-word fall-through FIFO that
// decouples the upstream and downstream handshakes and reports fill and delivered-flit count.
module link_fifo #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int MEM_LOG2  = 2
) (
    input  logic                           clk,
    input  logic                           a_rst,
    input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
    input  logic                           wr_ready_in,
    output logic                           r_ready_out,
    output logic [DATA_SIZE+ADDR_SIZE:0]   data_o,
    output logic                           wr_ready_out,
    input  logic                           r_ready_in,
    output logic [MEM_LOG2:0]              fill,
    output logic [31:0]                    flits_out
);

    localparam int FLIT_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int DEPTH     = 1 << MEM_LOG2;
    // A zero-bit pointer is not legal, so a depth-1 buffer still carries one pointer bit.
    localparam int PTR_W     = (MEM_LOG2 > 0) ? MEM_LOG2 : 1;

    localparam logic [MEM_LOG2:0] FULL_LEVEL = (MEM_LOG2+1)'(DEPTH);
    localparam logic [MEM_LOG2:0] FILL_ONE   = (MEM_LOG2+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    logic [FLIT_SIZE-1:0] mem_q [DEPTH];
    logic [FLIT_SIZE-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [MEM_LOG2:0]    fill_q, fill_d;
    logic [31:0]          flits_out_q, flits_out_d;
    logic                 push;
    logic                 pop;

    assign r_ready_out  = (fill_q != FULL_LEVEL) && !a_rst;
    assign wr_ready_out = (fill_q != '0);
    assign data_o       = mem_q[rd_ptr_q];
    assign fill         = fill_q;
    assign flits_out    = flits_out_q;

    always_comb begin
        push        = wr_ready_in && r_ready_out;
        pop         = wr_ready_out && r_ready_in;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        flits_out_d = flits_out_q;

        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
            flits_out_d = flits_out_q + 32'd1;
        end

        if (push && !pop) begin
            fill_d = fill_q + FILL_ONE;
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_ONE;
        end
    end

    // Storage is cleared too, so data_o reads zero straight after reset.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            flits_out_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            flits_out_q <= flits_out_d;
        end
    end

endmodule

// File: tb/tb_link_fifo.sv
// Randomised self-checking bench for link_fifo against a queue-based reference model.
module tb_link_fifo;

    localparam int FLIT_W = 37;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              a_rst;
    logic [FLIT_W-1:0] data_i;
    logic              wr_ready_in;
    logic              r_ready_out;
    logic [FLIT_W-1:0] data_o;
    logic              wr_ready_out;
    logic              r_ready_in;
    logic [2:0]        fill;
    logic [31:0]       flits_out;

    int compared;
    int mismatched;

    logic [FLIT_W-1:0] modelQ [$];
    logic [31:0]       modelOut;

    link_fifo #(.DATA_SIZE(32), .ADDR_SIZE(4), .MEM_LOG2(2)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .data_i       (data_i),
        .wr_ready_in  (wr_ready_in),
        .r_ready_out  (r_ready_out),
        .data_o       (data_o),
        .wr_ready_out (wr_ready_out),
        .r_ready_in   (r_ready_in),
        .fill         (fill),
        .flits_out    (flits_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Called at a negedge: drives inputs, checks outputs against the model, then
    // advances one clock and updates the model with what the handshake rules allow.
    task automatic applyStimulus(input logic wr, input logic [FLIT_W-1:0] din, input logic rd,
                                 output logic accepted);
        bit canPush;
        bit doPush;
        bit doPop;
        wr_ready_in = wr;
        data_i      = din;
        r_ready_in  = rd;
        #1;
        canPush = (modelQ.size() < DEPTH);
        checkOutput("r_ready_out", 64'(r_ready_out), 64'(canPush));
        checkOutput("wr_ready_out", 64'(wr_ready_out), 64'(modelQ.size() != 0));
        checkOutput("fill", 64'(fill), 64'(modelQ.size()));
        checkOutput("flits_out", 64'(flits_out), 64'(modelOut));
        if (modelQ.size() != 0) begin
            checkOutput("data_o", 64'(data_o), 64'(modelQ[0]));
        end
        doPush = wr && canPush;
        doPop  = rd && (modelQ.size() != 0);
        @(posedge clk);
        if (doPop) begin
            void'(modelQ.pop_front());
            modelOut++;
        end
        if (doPush) begin
            modelQ.push_back(din);
        end
        accepted = doPush;
        @(negedge clk);
    endtask

    function automatic logic [FLIT_W-1:0] randFlit();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[FLIT_W-1:0];
    endfunction

    initial begin
        logic              acc;
        logic [FLIT_W-1:0] burst [5];
        int                idx;
        compared    = 0;
        mismatched  = 0;
        modelOut    = 0;
        a_rst       = 1'b1;
        wr_ready_in = 1'b0;
        r_ready_in  = 1'b0;
        data_i      = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstRdy", 64'(r_ready_out), 64'(0));
        a_rst = 1'b0;
        #1;

        // Reset then idle.
        repeat (10) applyStimulus(1'b0, '0, 1'b0, acc);
        checkOutput("idleData", 64'(data_o), 64'(0));

        // Single flit.
        applyStimulus(1'b1, 37'h123456789, 1'b1, acc);
        checkOutput("singleData", 64'(data_o), 64'h123456789);
        checkOutput("singleValid", 64'(wr_ready_out), 64'(1));
        applyStimulus(1'b0, '0, 1'b1, acc);
        checkOutput("singleFill", 64'(fill), 64'(0));
        checkOutput("singleCount", 64'(flits_out), 64'(1));

        // Fill to full with downstream stalled; upstream holds the fifth flit.
        for (int i = 0; i < 5; i++) burst[i] = 37'h0A00000000 + 37'(i);
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, burst[idx], 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("fullFill", 64'(fill), 64'(4));
        checkOutput("fullRdy", 64'(r_ready_out), 64'(0));
        checkOutput("heldIdx", 64'(idx), 64'(4));
        for (int c = 0; c < 20 && (idx < 5 || modelQ.size() != 0); c++) begin
            applyStimulus(idx < 5, burst[idx < 5 ? idx : 0], 1'b1, acc);
            if (acc) idx++;
        end
        checkOutput("burstCount", 64'(flits_out), 64'(6));
        checkOutput("burstEmpty", 64'(fill), 64'(0));

        // Streaming at one flit per cycle across pointer wrap.
        applyStimulus(1'b1, 37'h100, 1'b0, acc);
        for (int i = 1; i < 20; i++) begin
            applyStimulus(1'b1, 37'h100 + 37'(i), 1'b1, acc);
            checkOutput("streamFill", 64'(fill), 64'(1));
        end
        applyStimulus(1'b0, '0, 1'b1, acc);
        checkOutput("streamCount", 64'(flits_out), 64'(26));

        // Asynchronous reset mid-burst at fill 3.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, randFlit(), 1'b0, acc);
        checkOutput("preRstFill", 64'(fill), 64'(3));
        #2;
        a_rst = 1'b1;
        #1;
        checkOutput("asyncFill", 64'(fill), 64'(0));
        checkOutput("asyncValid", 64'(wr_ready_out), 64'(0));
        checkOutput("asyncRdy", 64'(r_ready_out), 64'(0));
        checkOutput("asyncCount", 64'(flits_out), 64'(0));
        checkOutput("asyncData", 64'(data_o), 64'(0));
        @(negedge clk);
        a_rst = 1'b0;
        modelQ.delete();
        modelOut = 0;
        repeat (3) applyStimulus(1'b0, '0, 1'b1, acc);

        // Random traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), randFlit(), 1'($urandom_range(0, 1)), acc);
        end
        repeat (6) applyStimulus(1'b0, '0, 1'b1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
